// File: rtl/mod_n_seq_pkg.sv
// Shared types and helpers for the mod-N sequence checker.
package mod_n_seq_pkg;

  // Widest sample the successor helper supports; callers zero-extend into it.
  localparam int unsigned MaxDataW = 64;

  typedef enum logic [1:0] {
    StHunt,
    StAcq,
    StLocked
  } state_e;

  // Mod-N successor on a wide word; the caller truncates to its sample width, which also
  // gives the 2^WIDTH wrap for values at or above N.
  function automatic logic [MaxDataW-1:0] nxt_mod(input logic [MaxDataW-1:0] x,
                                                  input logic [MaxDataW-1:0] n);
    return (x == n - 64'd1) ? '0 : x + 64'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and soft clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;

  // Count up on inc, stop at the maximum value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mod_n_seq_checker.sv
// Mod-N sequence checker: hunts for a mod-N counting stream, locks after LOCK_CNT correct
// successors, then counts mismatches and wraps until MISS_MAX consecutive misses drop lock.
// Optional first-error capture ports are enabled by defining MOD_N_SEQ_CHECKER_FIRST_ERR_EN.
module mod_n_seq_checker
  import mod_n_seq_pkg::*;
#(
  parameter int unsigned N        = 256,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned MISS_MAX = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count,
`ifdef MOD_N_SEQ_CHECKER_FIRST_ERR_EN
  output logic [WIDTH-1:0] first_err_data,
  output logic [WIDTH-1:0] first_err_exp,
  output logic             first_err_vld,
`endif
  output logic [WIDTH-1:0] expected
);

  localparam int unsigned RunW  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MissW = $clog2(MISS_MAX + 1);

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
    return WIDTH'(nxt_mod(MaxDataW'(x), MaxDataW'(N)));
  endfunction

  state_e           state_q, state_d;
  logic [RunW-1:0]  run_q, run_d, run_inc;
  logic [MissW-1:0] miss_q, miss_d, miss_inc;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             err_pulse_q, err_pulse_d;
  logic             locked_q;
  logic             match, err_inc, wrap_inc;

  assign match    = (in_data == expected_q);
  assign run_inc  = run_q + RunW'(1);
  assign miss_inc = miss_q + MissW'(1);

  // Next-state, counter increments and registered-output next values.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    miss_d      = miss_q;
    expected_d  = expected_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    wrap_inc    = 1'b0;
    if (clear) begin
      // Soft clear wins over any sample in the same cycle.
      state_d    = StHunt;
      run_d      = '0;
      miss_d     = '0;
      expected_d = '0;
    end else if (in_valid) begin
      // Every accepted sample resyncs the prediction to its own successor.
      expected_d = nxt(in_data);
      unique case (state_q)
        StHunt: begin
          run_d   = '0;
          state_d = StAcq;
        end
        StAcq: begin
          if (match) begin
            run_d = run_inc;
            if (run_inc == RunW'(LOCK_CNT)) begin
              state_d = StLocked;
              miss_d  = '0;
            end
          end else begin
            run_d = '0;
          end
        end
        StLocked: begin
          if (match) begin
            miss_d   = '0;
            wrap_inc = (in_data == WIDTH'(N - 1));
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            miss_d      = miss_inc;
            if (miss_inc == MissW'(MISS_MAX)) begin
              state_d = StHunt;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      run_q       <= '0;
      miss_q      <= '0;
      expected_q  <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      expected_q  <= expected_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= (state_d == StLocked);
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (err_inc),
    .cnt (err_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (wrap_inc),
    .cnt (wrap_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign expected  = expected_q;

`ifdef MOD_N_SEQ_CHECKER_FIRST_ERR_EN
  logic             fe_vld_q;
  logic [WIDTH-1:0] fe_data_q, fe_exp_q;

  // Capture only the first locked mismatch since the last rst/clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      fe_vld_q  <= 1'b0;
      fe_data_q <= '0;
      fe_exp_q  <= '0;
    end else if (in_valid && (state_q == StLocked) && !match && !fe_vld_q) begin
      fe_vld_q  <= 1'b1;
      fe_data_q <= in_data;
      fe_exp_q  <= expected_q;
    end
  end

  assign first_err_vld  = fe_vld_q;
  assign first_err_data = fe_data_q;
  assign first_err_exp  = fe_exp_q;
`endif

endmodule

// File: tb/tb_mod_n_seq_checker.sv
// Scoreboard bench for mod_n_seq_checker: the driver predicts each cycle's outputs with a
// behavioural model and queues them; the monitor compares after every clock edge.
module tb_mod_n_seq_checker;

  localparam int PN   = 8;
  localparam int PW   = 4;
  localparam int PLK  = 3;
  localparam int PMM  = 2;
  localparam int PCW  = 4;
  localparam int CMAX = (1 << PCW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_data = '0;
  logic          clear = 1'b0;
  logic          locked, err_pulse;
  logic [PCW-1:0] err_count, wrap_count;
  logic [PW-1:0] expected;
`ifdef MOD_N_SEQ_CHECKER_FIRST_ERR_EN
  logic [PW-1:0] first_err_data, first_err_exp;
  logic          first_err_vld;
`endif

  mod_n_seq_checker #(
    .N(PN), .WIDTH(PW), .LOCK_CNT(PLK), .MISS_MAX(PMM), .CNT_W(PCW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .clear          (clear),
    .locked         (locked),
    .err_pulse      (err_pulse),
    .err_count      (err_count),
    .wrap_count     (wrap_count),
`ifdef MOD_N_SEQ_CHECKER_FIRST_ERR_EN
    .first_err_data (first_err_data),
    .first_err_exp  (first_err_exp),
    .first_err_vld  (first_err_vld),
`endif
    .expected       (expected)
  );

  always #5 clk = ~clk;

  typedef struct {
    int locked;
    int pulse;
    int errc;
    int wrapc;
    int exp_v;
    int fv;
    int fd;
    int fe;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 = searching, 1 = acquiring, 2 = locked.
  int m_mode = 0, m_run = 0, m_miss = 0, m_exp = 0, m_err = 0, m_wrap = 0, m_pulse = 0;
  int m_fv = 0, m_fd = 0, m_fe = 0;

  function automatic int mnxt(input int x);
    return (x == PN - 1) ? 0 : (x + 1) % (1 << PW);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_miss = 0; m_exp = 0; m_err = 0; m_wrap = 0; m_pulse = 0;
    m_fv = 0; m_fd = 0; m_fe = 0;
  endtask

  task automatic model_step(input bit v, input int d);
    m_pulse = 0;
    if (!v) return;
    if (m_mode == 0) begin
      m_run  = 0;
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (d == m_exp) begin
        m_run++;
        if (m_run == PLK) begin
          m_mode = 2;
          m_miss = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (d == m_exp) begin
        m_miss = 0;
        if (d == PN - 1 && m_wrap < CMAX) m_wrap++;
      end else begin
        m_pulse = 1;
        if (m_err < CMAX) m_err++;
        if (m_fv == 0) begin
          m_fv = 1; m_fd = d; m_fe = m_exp;
        end
        m_miss++;
        if (m_miss == PMM) m_mode = 0;
      end
    end
    m_exp = mnxt(d);
  endtask

  // Drive one cycle of inputs, advance the model and queue the predicted outputs.
  task automatic step(input bit r, input bit c, input bit v, input int d);
    exp_t e;
    @(negedge clk);
    rst = r; clear = c; in_valid = v; in_data = PW'(d);
    if (r || c) model_reset();
    else model_step(v, d);
    e.locked = (m_mode == 2) ? 1 : 0;
    e.pulse = m_pulse; e.errc = m_err; e.wrapc = m_wrap; e.exp_v = m_exp;
    e.fv = m_fv; e.fd = m_fd; e.fe = m_fe;
    sb.push_back(e);
  endtask

  task automatic feed(input int d);
    step(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one queued prediction per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("locked", (locked === 1'b1) ? 1 : ((locked === 1'b0) ? 0 : -1), e.locked);
        check("err_pulse", (err_pulse === 1'b1) ? 1 : ((err_pulse === 1'b0) ? 0 : -1),
              e.pulse);
        check("err_count", ($isunknown(err_count)) ? -1 : int'(err_count), e.errc);
        check("wrap_count", ($isunknown(wrap_count)) ? -1 : int'(wrap_count), e.wrapc);
        check("expected", ($isunknown(expected)) ? -1 : int'(expected), e.exp_v);
`ifdef MOD_N_SEQ_CHECKER_FIRST_ERR_EN
        check("first_err_vld", (first_err_vld === 1'b1) ? 1 : 0, e.fv);
        check("first_err_data", int'(first_err_data), e.fd);
        check("first_err_exp", int'(first_err_exp), e.fe);
`endif
      end
    end
  end

  initial begin
    int a, e, bad, s, d, waited;
    bit v;
    // Reset.
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    idle();
    // Acquire: 7 arrives before lock, so no wrap.
    feed(5); feed(6); feed(7); feed(0);
    // Wrap count while locked.
    for (int i = 1; i <= 7; i++) feed(i);
    feed(0);
    // Single error and resync from expected=3.
    feed(1); feed(2); feed(5); feed(6); idle();
    // Loss of lock on two consecutive mismatches, then a sample enters acquisition.
    feed(2); feed(2); feed(3); idle();
    // Clear together with a valid sample.
    step(1'b0, 1'b1, 1'b1, 4);
    // Saturation: 10 rounds of lock + two mismatches = 20 errors.
    for (int r = 0; r < 10; r++) begin
      a = $urandom_range(0, PN - 1);
      feed(a); a = mnxt(a); feed(a); a = mnxt(a); feed(a); a = mnxt(a); feed(a);
      e   = mnxt(a);
      bad = (e + 3) % PN;
      feed(bad); feed(bad);
    end
    step(1'b0, 1'b1, 1'b1, 2);
    idle();
    // Gaps during acquisition, then reset while locked.
    feed(2); idle(); feed(3); idle(); idle(); feed(4); feed(5); idle();
    feed(6); feed(1);
    step(1'b1, 1'b0, 1'b1, 6);
    idle();
    feed(0); feed(1); feed(2); feed(3); feed(9); feed(4); feed(7); feed(7);
    // Randomised stream: mostly correct successors, some corruption, rare clear/reset.
    s = 0;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : s;
      if (v) s = mnxt(d);
      step(($urandom_range(0, 249) == 0), ($urandom_range(0, 149) == 0), v, d);
    end
    idle();
    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (sb.size() != 0 && waited < 10) begin
      @(posedge clk);
      #2;
      waited++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
